// File: rtl/apb_pkg.sv
// Shared types and default sizing for the round-robin APB master.
// The state encoding is visible here so the bench and any wrappers can decode it.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_NREQ    = 2;
  localparam int APB_AW      = 16;
  localparam int APB_DW      = 32;
  localparam int APB_TIMEOUT = 16;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// Request/response ports plus the APB3 bus, bundled for the shared APB master.
// The master modport is the arbiter's view; slave is the mirror seen by requesters and the peripheral.
interface apb_master_arb_if
  import apb_pkg::*;
#(
  parameter int NREQ = APB_NREQ,
  parameter int AW   = APB_AW,
  parameter int DW   = APB_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;

  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata;
  logic               pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the pointer, wrapping.
// The pointer register lives in the caller so this block stays stateless.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // The extra sum bit lets ptr+offset exceed NREQ-1 before folding back, for any NREQ.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end
      w_cand = w_sum[IW-1:0];
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB3 master shared by NREQ requesters: round-robin accept, SETUP/ACCESS sequencing,
// bounded wait on pready, and a registered one-cycle completion pulse per requester.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int NREQ    = APB_NREQ,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              pclk,
  input  logic              preset,
  apb_master_arb_if.master  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  apb_state_t      r_state;
  apb_state_t      w_next;

  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx;
  logic [NREQ-1:0] w_grant;
  logic            w_any;
  logic            w_accept;
  logic            w_done_ok;
  logic            w_timeout;

  logic            r_write;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;

  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_rsp_err;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_done_ok = (r_state == ACCESS) && bus.pready;
  assign w_timeout = (r_state == ACCESS) && !bus.pready && (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_addr  = bus.req_addr[i*AW +: AW];
        w_wdata = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant is only exposed in IDLE, so a request can never be accepted mid-transfer.
  always_comb begin
    w_next        = r_state;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.req_ready = '0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = w_grant;
        if (w_any) begin
          w_next = SETUP;
        end
      end
      SETUP: begin
        bus.psel = 1'b1;
        w_next   = ACCESS;
      end
      ACCESS: begin
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        if (w_done_ok || w_timeout) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request latch and round-robin pointer; APB address/data hold their value between transfers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_ptr   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_ptr   <= IW'(rr_next(32'(w_idx), NREQ));
      r_idx   <= w_idx;
      r_write <= bus.req_write[w_idx];
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_cnt <= '0;
    end else if ((r_state == ACCESS) && !bus.pready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A reset on the completing edge wins, so an aborted transfer never pulses rsp_valid.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      if (w_done_ok) begin
        r_rsp_valid[r_idx] <= 1'b1;
        r_rsp_rdata        <= r_write ? '0 : bus.prdata;
      end else if (w_timeout) begin
        r_rsp_valid[r_idx] <= 1'b1;
        r_rsp_err          <= 1'b1;
      end
    end
  end

  assign bus.pwrite    = r_write;
  assign bus.paddr     = r_addr;
  assign bus.pwdata    = r_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
